// File: rtl/ysyx_23060077_ifu.sv
// Instruction fetch unit: owns the PC, issues one AR/R read per instruction and
// hands {inst, pc, fault} to decode over a valid/ready handshake.
module ysyx_23060077_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ifu_ar_valid,
    input  logic                  ifu_ar_ready,
    output logic [ADDR_WIDTH-1:0] ifu_ar_addr,
    input  logic                  ifu_r_valid,
    output logic                  ifu_r_ready,
    input  logic [INST_WIDTH-1:0] ifu_r_data,
    input  logic [1:0]            ifu_r_resp,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   pc, pc_n;
    logic                    drop, drop_n;
    logic                    pend_valid, pend_valid_n;
    logic [ADDR_WIDTH-1:0]   pend_pc, pend_pc_n;
    logic [INST_WIDTH-1:0]   inst_n;
    logic [ADDR_WIDTH-1:0]   opc_n;
    logic                    fault_n;
    logic [ADDR_WIDTH-1:0]   redir_tgt;
    logic                    ar_hs, r_hs, out_hs;

    assign ifu_ar_valid = (state == S_AR);
    assign ifu_ar_addr  = pc;
    assign ifu_r_ready  = (state == S_R);
    assign out_valid    = (state == S_OUT);

    assign redir_tgt = redirect_pc & ~ADDR_WIDTH'(3);
    assign ar_hs     = ifu_ar_valid & ifu_ar_ready;
    assign r_hs      = ifu_r_valid & ifu_r_ready;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drop_n       = drop;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        inst_n       = out_inst;
        opc_n        = out_pc;
        fault_n      = out_fault;
        case (state)
            S_IDLE: begin
                state_n = S_AR;
                if (redirect_valid) pc_n = redir_tgt;
            end
            S_AR: begin
                // The presented address must not move before its handshake, so a
                // redirect here parks in pend_pc and the resulting beat is dropped.
                if (redirect_valid) drop_n = 1'b1;
                if (ar_hs) begin
                    state_n      = S_R;
                    pend_valid_n = 1'b0;
                    if (redirect_valid)  pc_n = redir_tgt;
                    else if (pend_valid) pc_n = pend_pc;
                end else if (redirect_valid) begin
                    pend_valid_n = 1'b1;
                    pend_pc_n    = redir_tgt;
                end
            end
            S_R: begin
                if (redirect_valid) pc_n = redir_tgt;
                if (r_hs) begin
                    drop_n = 1'b0;
                    if (drop || redirect_valid) begin
                        state_n = S_AR;
                    end else begin
                        state_n = S_OUT;
                        inst_n  = ifu_r_data;
                        opc_n   = pc;
                        fault_n = |ifu_r_resp;
                    end
                end else if (redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_n    = redir_tgt;
                    state_n = S_AR;
                end else if (out_hs) begin
                    pc_n    = pc + ADDR_WIDTH'(4);
                    state_n = S_AR;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            out_inst   <= '0;
            out_pc     <= '0;
            out_fault  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drop       <= drop_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
            out_inst   <= inst_n;
            out_pc     <= opc_n;
            out_fault  <= fault_n;
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_ifu.sv
// Bench for the fetch unit: directed vector table, mid-fetch reset, then random
// bus/decode/redirect traffic checked against an instruction-stream model.
module tb_ysyx_23060077_ifu;

    localparam logic [31:0] RESET_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_ar_valid, ifu_ar_ready;
    logic [31:0] ifu_ar_addr;
    logic        ifu_r_valid, ifu_r_ready;
    logic [31:0] ifu_r_data;
    logic [1:0]  ifu_r_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc;
    logic        out_fault;

    ysyx_23060077_ifu #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
        .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data),
        .ifu_r_resp(ifu_r_resp), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          ordy;
        bit          arr;
        bit          redir;
        logic [31:0] rpc;
        logic [31:0] mdata;
        logic [1:0]  mresp;
        int          mdly;
        bit          e_arv;
        bit          e_rr;
        bit          e_ov;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        bit          e_fault;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_errors = 0;
    int deliveries = 0;

    // memory responder state (one read in flight at most)
    bit          outstanding;
    int          dly_cnt;
    logic [31:0] beat_addr, beat_data;
    logic [1:0]  beat_resp;
    logic [31:0] last_addr, last_data;
    logic [1:0]  last_resp;

    // instruction-stream model: PC of the next instruction decode should see
    logic [31:0] model_pc;

    bit          p_arv, p_arr, p_ov, p_ordy, p_redir, p_fault;
    logic [31:0] p_addr, p_pc, p_inst;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit ordy, input bit arr, input bit redir, input logic [31:0] rpc,
                                input logic [31:0] mdata, input logic [1:0] mresp, input int mdly,
                                input bit e_arv, input bit e_rr, input bit e_ov, input logic [31:0] e_addr,
                                input logic [31:0] e_pc, input logic [31:0] e_inst, input bit e_fault);
        vec_t v;
        v.ordy = ordy; v.arr = arr; v.redir = redir; v.rpc = rpc;
        v.mdata = mdata; v.mresp = mresp; v.mdly = mdly;
        v.e_arv = e_arv; v.e_rr = e_rr; v.e_ov = e_ov; v.e_addr = e_addr;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic clear_bench_state();
        outstanding = 1'b0; dly_cnt = 0;
        ifu_r_valid = 1'b0; ifu_r_data = '0; ifu_r_resp = 2'b00;
        ifu_ar_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_pc = RESET_PC;
        last_addr = '0; last_data = '0; last_resp = 2'b00;
        p_arv = 0; p_arr = 0; p_ov = 0; p_ordy = 0; p_redir = 0; p_fault = 0;
        p_addr = '0; p_pc = '0; p_inst = '0;
    endtask

    // Called at a falling edge: check the state settled since the last rising
    // edge, drive inputs for the next rising edge and advance the model.
    task automatic step(input bit ordy, input bit arr, input bit redir, input logic [31:0] rpc,
                        input logic [31:0] mdata, input logic [1:0] mresp, input int mdly);
        bit ar_hs, r_hs, out_hs;
        if (p_arv && !p_arr)
            check("ar_hold", 96'({ifu_ar_valid, ifu_ar_addr}), 96'({1'b1, p_addr}));
        if (p_ov && !p_ordy && !p_redir)
            check("out_hold", 96'({out_valid, out_fault, out_pc, out_inst}),
                  96'({1'b1, p_fault, p_pc, p_inst}));
        check("single_outstanding", 96'(ifu_ar_valid & outstanding), 96'(0));
        check("r_ready_without_read", 96'(ifu_r_ready & ~outstanding), 96'(0));

        out_ready = ordy; ifu_ar_ready = arr; redirect_valid = redir; redirect_pc = rpc;
        if (outstanding && dly_cnt == 0) begin
            ifu_r_valid = 1'b1; ifu_r_data = beat_data; ifu_r_resp = beat_resp;
        end else begin
            ifu_r_valid = 1'b0; ifu_r_data = $urandom; ifu_r_resp = 2'b00;
            if (outstanding) dly_cnt--;
        end

        ar_hs  = ifu_ar_valid & arr;
        r_hs   = ifu_r_valid & ifu_r_ready;
        out_hs = out_valid & ordy;

        if (out_hs) begin
            check("deliver_pc", 96'(out_pc), 96'(model_pc));
            check("deliver_data", 96'({out_fault, out_inst}), 96'({|last_resp, last_data}));
            check("fetch_addr", 96'(last_addr), 96'(model_pc));
            deliveries++;
        end
        if (r_hs) begin
            outstanding = 1'b0;
            last_addr = beat_addr; last_data = beat_data; last_resp = beat_resp;
        end
        if (ar_hs) begin
            outstanding = 1'b1;
            beat_addr = ifu_ar_addr; beat_data = mdata; beat_resp = mresp; dly_cnt = mdly;
        end
        if (redir)       model_pc = rpc & 32'hFFFF_FFFC;
        else if (out_hs) model_pc = model_pc + 32'd4;

        p_arv = ifu_ar_valid; p_arr = arr; p_addr = ifu_ar_addr;
        p_ov = out_valid; p_ordy = ordy; p_redir = redir;
        p_fault = out_fault; p_pc = out_pc; p_inst = out_inst;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clock);
            check($sformatf("flags_row%0d", i), 96'({ifu_ar_valid, ifu_r_ready, out_valid}),
                  96'({tbl[i].e_arv, tbl[i].e_rr, tbl[i].e_ov}));
            if (tbl[i].e_arv)
                check($sformatf("ar_addr_row%0d", i), 96'(ifu_ar_addr), 96'(tbl[i].e_addr));
            if (tbl[i].e_ov)
                check($sformatf("out_row%0d", i), 96'({out_fault, out_pc, out_inst}),
                      96'({tbl[i].e_fault, tbl[i].e_pc, tbl[i].e_inst}));
            step(tbl[i].ordy, tbl[i].arr, tbl[i].redir, tbl[i].rpc,
                 tbl[i].mdata, tbl[i].mresp, tbl[i].mdly);
        end
    endtask

    initial begin
        int start_deliv;
        // rows 0..23: first fetch, stalls, redirect in S_R, fault, redirect with handshake
        tbl.push_back(mk(0,1,0,0, 32'h0000_0297,2'b00,0, 1,0,0, 32'h3000_0000, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,1, 0, 32'h3000_0000,32'h0000_0297,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,1, 0, 32'h3000_0000,32'h0000_0297,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,0, 0,0,0, 1,0,0, 32'h3000_0004, 0,0,0));
        tbl.push_back(mk(0,1,0,0, 32'hDEAD_BEEF,2'b00,2, 1,0,0, 32'h3000_0004, 0,0,0));
        tbl.push_back(mk(0,0,1,32'h8000_0010, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(0,1,0,0, 32'h1111_1111,2'b10,0, 1,0,0, 32'h8000_0010, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(1,0,1,32'h8000_0102, 0,0,0, 0,0,1, 0, 32'h8000_0010,32'h1111_1111,1));
        tbl.push_back(mk(0,1,0,0, 32'h2222_2222,2'b00,0, 1,0,0, 32'h8000_0100, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,1, 0, 32'h8000_0100,32'h2222_2222,0));
        tbl.push_back(mk(0,1,0,0, 32'h3333_3333,2'b00,5, 1,0,0, 32'h8000_0104, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        // rows 24..30: restart after reset, redirect to the top of memory, wrap to 0
        tbl.push_back(mk(0,1,0,0, 32'hAAAA_0001,2'b00,0, 1,0,0, RESET_PC, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(1,0,1,32'hFFFF_FFFF, 0,0,0, 0,0,1, 0, RESET_PC,32'hAAAA_0001,0));
        tbl.push_back(mk(0,1,0,0, 32'hAAAA_0002,2'b00,0, 1,0,0, 32'hFFFF_FFFC, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,1,0, 0, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,1, 0, 32'hFFFF_FFFC,32'hAAAA_0002,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 1,0,0, 32'h0000_0000, 0,0,0));

        reset = 1'b1;
        clear_bench_state();
        repeat (2) @(negedge clock);
        check("reset_outputs", 96'({ifu_ar_valid, ifu_r_ready, out_valid, out_fault, out_pc, out_inst}), 96'(0));
        check("reset_ar_addr", 96'(ifu_ar_addr), 96'(RESET_PC));
        reset = 1'b0;

        run_rows(0, 23);

        // reset pulse while a read is outstanding in S_R
        #2 reset = 1'b1;
        clear_bench_state();
        #1;
        check("mid_reset_outputs", 96'({ifu_ar_valid, ifu_r_ready, out_valid, out_fault, out_pc, out_inst}), 96'(0));
        check("mid_reset_ar_addr", 96'(ifu_ar_addr), 96'(RESET_PC));
        @(negedge clock);
        reset = 1'b0;

        run_rows(24, 30);

        start_deliv = deliveries;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                 $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
                 int'($urandom_range(0, 3)));
        end
        check("random_progress", 96'((deliveries - start_deliv) > 100), 96'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
